// File: rtl/instr_sequencer_if.sv
// Sequencer-side bundle: control inputs, instruction memory port, decoded fields and status.
// master = sequencer, slave = surrounding datapath / memory / test environment.
interface instr_sequencer_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              start;
   logic              step_mode;
   logic              step;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_data;
   logic [3:0]        opcode;
   logic [3:0]        rd_addr;
   logic [3:0]        rs2_imm;
   logic [3:0]        rs1_addr;
   logic              wb_en;
   logic              read_valid;
   logic              busy;
   logic              halted;
   logic [7:0]        instr_count;

   modport master (
      input  start, step_mode, step, imem_data,
      output imem_addr, opcode, rd_addr, rs2_imm, rs1_addr,
      output wb_en, read_valid, busy, halted, instr_count
   );

   modport slave (
      output start, step_mode, step, imem_data,
      input  imem_addr, opcode, rd_addr, rs2_imm, rs1_addr,
      input  wb_en, read_valid, busy, halted, instr_count
   );
endinterface

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer: FETCH -> DECODE -> EXEC -> WB, with optional single-step
// pause before every fetch and a HALT state entered on an all-zero instruction word.
module instr_sequencer #(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned LAST_ADDR = 15
) (
   input logic               clk,
   input logic               rst,
   instr_sequencer_if.master bus
);
   localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);
   localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);
   localparam logic [3:0]        OpNop  = 4'b0000;
   localparam logic [3:0]        OpRead = 4'b0010;

   typedef enum logic [2:0] {
      StIdle, StStepWait, StFetch, StDecode, StExec, StWb, StHalt
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              wb_en_q, wb_en_d;
   logic              rv_q, rv_d;

   logic [3:0] ir_op;
   assign ir_op = ir_q[15:12];

   // Next-state, PC/IR/count update and the strobes that become registered in WB.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      wb_en_d = 1'b0;
      rv_d    = 1'b0;
      unique case (state_q)
         StIdle, StHalt: begin
            if (bus.start) begin
               pc_d    = '0;
               cnt_d   = '0;
               state_d = bus.step_mode ? StStepWait : StFetch;
            end
         end
         StStepWait: begin
            if (bus.step) state_d = StFetch;
         end
         StFetch: begin
            state_d = StDecode;
         end
         StDecode: begin
            if (bus.imem_data == 16'h0000) begin
               ir_d    = '0;
               state_d = StHalt;
            end else begin
               ir_d    = bus.imem_data;
               state_d = StExec;
            end
         end
         StExec: begin
            // Strobes are computed here so they are register outputs during WB only.
            wb_en_d = (ir_op != OpNop) && (ir_op != OpRead);
            rv_d    = (ir_op == OpRead);
            state_d = StWb;
         end
         StWb: begin
            pc_d    = (pc_q == LastPc) ? '0 : pc_q + PcOne;
            cnt_d   = cnt_q + 8'd1;
            state_d = bus.step_mode ? StStepWait : StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
         wb_en_q <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         wb_en_q <= wb_en_d;
         rv_q    <= rv_d;
      end
   end

   // Status and field outputs; opcode is forced to NOP while not executing a program.
   always_comb begin
      bus.busy   = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                   (state_q == StWb) || (state_q == StStepWait);
      bus.halted = (state_q == StHalt);
      bus.opcode = ((state_q == StIdle) || (state_q == StStepWait) || (state_q == StHalt)) ?
                   4'b0000 : ir_op;
   end

   assign bus.imem_addr   = pc_q;
   assign bus.rd_addr     = ir_q[11:8];
   assign bus.rs2_imm     = ir_q[7:4];
   assign bus.rs1_addr    = ir_q[3:0];
   assign bus.wb_en       = wb_en_q;
   assign bus.read_valid  = rv_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: stimulus pushes expected retirements (word, strobes, count, cycle) into a
// queue from a program-walk model; a negedge monitor pops them whenever the DUT retires.
module tb_instr_sequencer;
   localparam int unsigned AW   = 4;
   localparam int unsigned LAST = 15;

   typedef struct {
      logic [15:0] ir;
      logic        wb;
      logic        rv;
      logic [7:0]  cnt;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   instr_sequencer_if #(.ADDR_W(AW)) bus ();

   instr_sequencer #(.ADDR_W(AW), .LAST_ADDR(LAST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [16];
   always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

   int   cyc = 0;
   logic rst_s = 1'b1;
   logic start_s = 1'b0;
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_s   <= rst;
      start_s <= bus.start;
   end

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   logic       mon_en = 1'b0;
   logic       p_wb = 1'b0, p_rv = 1'b0;
   logic [3:0] p_op, p_rd, p_rs2, p_rs1;
   logic [7:0] p_cnt = 8'd0;
   exp_t       e;

   always @(negedge clk) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_retire: nothing seen, expected word %h at cycle %0d",
                     sb[0].ir, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (((bus.instr_count != p_cnt) || p_wb || p_rv) && !rst_s &&
             !(start_s && bus.instr_count == 8'd0 && !p_wb && !p_rv)) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_retire: count %0d wb %0d rv %0d, expected none",
                        bus.instr_count, p_wb, p_rv);
            end else begin
               e = sb.pop_front();
               chk("retire_cycle", cyc, e.cyc);
               chk("instr_count", bus.instr_count, e.cnt);
               chk("wb_en", p_wb, e.wb);
               chk("read_valid", p_rv, e.rv);
               chk("opcode", p_op, e.ir[15:12]);
               chk("rd_addr", p_rd, e.ir[11:8]);
               chk("rs2_imm", p_rs2, e.ir[7:4]);
               chk("rs1_addr", p_rs1, e.ir[3:0]);
            end
         end
      end
      p_wb  = bus.wb_en;
      p_rv  = bus.read_valid;
      p_op  = bus.opcode;
      p_rd  = bus.rd_addr;
      p_rs2 = bus.rs2_imm;
      p_rs1 = bus.rs1_addr;
      p_cnt = bus.instr_count;
   end

   // ---------------- model / stimulus helpers ----------------
   // Instruction i of a run sits at address i mod 16; a zero word halts instead of retiring.
   function automatic bit push_one(input int i, input int c);
      logic [15:0] w;
      exp_t        x;
      w = mem[i % (LAST + 1)];
      if (w == 16'h0000) return 1'b0;
      x.ir  = w;
      x.wb  = (w[15:12] != 4'h0) && (w[15:12] != 4'h2);
      x.rv  = (w[15:12] == 4'h2);
      x.cnt = 8'((i + 1) % 256);
      x.cyc = c;
      sb.push_back(x);
      return 1'b1;
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w[11:0] = 12'($urandom);
      case ($urandom_range(3))
         0:       w[15:12] = 4'h0;
         1:       w[15:12] = 4'h2;
         default: w[15:12] = 4'($urandom_range(15));
      endcase
      if (w == 16'h0000) w = 16'h0100;
      return w;
   endfunction

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic do_start(input bit sm, output int p);
      bus.step_mode = sm;
      bus.start     = 1'b1;
      p             = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_wb_en", bus.wb_en, 0);
      chk("rst_read_valid", bus.read_valid, 0);
      chk("rst_opcode", bus.opcode, 0);
      chk("rst_count", bus.instr_count, 0);
      chk("rst_pc", bus.imem_addr, 0);
   endtask

   // Free-running run of up to n instructions; halts on a zero word, else reset mid-flight.
   task automatic run_free(input int n, input bit spur);
      int p;
      int got = 0;
      int r;
      do_start(1'b0, p);
      for (int i = 0; i < n; i++) begin
         if (!push_one(i, p + 4 * (i + 1))) break;
         got++;
      end
      if (spur && got > 0) begin
         // start during a DECODE must not disturb pc, count or cadence
         wait_cyc(p + 4 * $urandom_range(got - 1) + 1);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      if (got < n) begin
         wait_cyc(p + 4 * got + 1);
         chk("pre_halt_busy", bus.busy, 1);
         chk("pre_halt_halted", bus.halted, 0);
         @(negedge clk);
         chk("halted", bus.halted, 1);
         chk("halt_busy", bus.busy, 0);
         chk("halt_opcode", bus.opcode, 0);
         chk("halt_pc", bus.imem_addr, got % (LAST + 1));
         chk("halt_count", bus.instr_count, got % 256);
         repeat (2) @(negedge clk);
      end else begin
         r = $urandom_range(3);
         wait_cyc(p + 4 * got + r);
         do_reset();
      end
   endtask

   task automatic run_step(input int nsteps);
      int p;
      int q;
      do_start(1'b1, p);
      wait_cyc(p + 2 + $urandom_range(3));
      chk("step_wait_busy", bus.busy, 1);
      chk("step_wait_opcode", bus.opcode, 0);
      chk("step_wait_count", bus.instr_count, 0);
      for (int k = 0; k < nsteps; k++) begin
         bus.step = 1'b1;
         q        = cyc + 1;
         void'(push_one(k, q + 4));
         @(negedge clk);
         bus.step = 1'b0;
         // extra step while the instruction is in flight must be ignored
         wait_cyc(q + $urandom_range(3));
         bus.step = 1'b1;
         @(negedge clk);
         bus.step = 1'b0;
         wait_cyc(q + 4 + $urandom_range(1, 3));
         chk("step_hold_busy", bus.busy, 1);
         chk("step_hold_count", bus.instr_count, k + 1);
      end
      do_reset();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.start     = 1'b0;
      bus.step      = 1'b0;
      bus.step_mode = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.step  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.step  = 1'b0;
      rst       = 1'b0;
      chk("init_busy", bus.busy, 0);
      chk("init_halted", bus.halted, 0);
      chk("init_count", bus.instr_count, 0);
      chk("init_opcode", bus.opcode, 0);
      mon_en = 1'b1;
      @(negedge clk);

      // ADD then halt word
      mem[0] = 16'hA312;
      mem[1] = 16'h0000;
      run_free(16, 1'b0);

      // Read then non-zero NOP, then halt (restart from HALT)
      mem[0] = 16'h2005;
      mem[1] = 16'h0100;
      mem[2] = 16'h0000;
      run_free(16, 1'b0);

      // sixteen non-zero words: pc wraps, count wraps 255 -> 0
      for (int i = 0; i < 16; i++) mem[i] = rand_word();
      run_free(260, 1'b1);

      // single-step mode
      for (int i = 0; i < 16; i++) mem[i] = rand_word();
      run_step(4);

      // random programs, optional halt word, spurious start pulses
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 16; i++) mem[i] = rand_word();
         if ($urandom_range(1) == 1) mem[$urandom_range(1, 15)] = 16'h0000;
         run_free($urandom_range(4, 40), 1'($urandom_range(1)));
      end

      repeat (8) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
